csr_stream_feeder: RTL and testbench
====================================

Name: csr_stream_feeder

Overview:
- Transmit end of the scheduler's input protocol.
- Reads a CSR sparse input matrix and a dense weight matrix from on-chip SRAMs.
- For each weight column pair it first drives the weight-load stream (switch pulse plus 64 interleaved words), then streams every nonzero input element (data, row, col) and ends the pass with a done pulse.
- Repeats for all column pairs, then raises finish.

Parameters:
- DATA_BITS, 16, element/weight width
- N_ROWS, 100, input matrix rows
- ROW_BITS, 7, row index width
- COL_BITS, 5, input column index width (= weight rows index)
- W_ROWS, 32, weight rows per column
- W_COLS, 8, weight columns (even)
- WCOL_BITS, 3, weight column index width
- NNZ_BITS, 12, nonzero address width
- WADDR_BITS, 8, weight memory address width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- i_start  in  1  1-cycle pulse, begins job (ignored unless IDLE)
- o_rp_addr  out  ROW_BITS  row-pointer SRAM address (N_ROWS+1 entries)
- i_rp_rdata  in  NNZ_BITS  row-pointer data, 1-cycle read latency
- o_nz_addr  out  NNZ_BITS  value/col SRAM address
- i_nz_val  in  DATA_BITS  value read data, 1-cycle latency
- i_nz_col  in  COL_BITS  column read data, 1-cycle latency
- o_w_addr  out  WADDR_BITS  weight SRAM address = col*W_ROWS+row
- i_w_rdata  in  DATA_BITS  weight read data, 1-cycle latency
- o_rdy  out  1  element valid
- o_data  out  DATA_BITS  element value
- o_row_ptr  out  ROW_BITS  element row index
- o_col_idx  out  COL_BITS  element column index
- o_done  out  1  1-cycle end-of-pass pulse
- o_switch  out  1  1-cycle weight-load request pulse
- o_w_data  out  DATA_BITS  weight word (= i_w_rdata)
- o_w_col_idx  out  WCOL_BITS  column of current weight word
- i_w_switch  in  1  scheduler weight-load busy; high = current word consumed this cycle
- o_busy  out  1  not IDLE
- o_finish  out  1  1-cycle pulse after last pass

Behaviour:
- Reset: every output 0; state IDLE; pair counter p=0. Reset mid-job aborts immediately; no done or finish is emitted.
- States: IDLE, W_REQ, W_LOAD, RP_INIT, RP_FETCH, ELEM, DONE, FIN.
- IDLE -> W_REQ on i_start; p=0.
- W_REQ (1 cycle): o_switch=1. Weight word index k=0. o_w_addr issues word 0 (col 2p, row 0).
- W_LOAD: word k maps to col 2p+(k&1), row k>>1. o_w_col_idx = column of word k. o_w_addr is combinational: the address of word k+1 when i_w_switch=1, else word k, so o_w_data is always valid for word k.
  - k increments on each cycle with i_w_switch=1.
  - After k=63 is consumed (i_w_switch then falls) -> RP_INIT.
  - i_w_switch low before the first rise: wait, holding word 0.
- RP_INIT: read rp[0] into cur pointer; r=0 -> RP_FETCH.
- RP_FETCH (2 cycles): read rp[r+1] into end pointer.
  - If end==cur (empty row): r++; if r==N_ROWS -> DONE, else stay.
  - Otherwise -> ELEM.
- ELEM: one nz address per cycle, cur..end-1. o_rdy/o_data/o_col_idx/o_row_ptr=r appear 1 cycle after the address, with o_rdy high exactly one cycle per element.
  - After issuing end-1: r++ and -> RP_FETCH, or -> DONE if r==N_ROWS.
  - o_rdy=0 during RP_FETCH gaps. Data outputs are 0 whenever o_rdy=0.
- DONE: waits until the last element's o_rdy has been emitted, then the next cycle o_done=1 for 1 cycle.
  - p++; if p==W_COLS/2 -> FIN, else -> W_REQ.
- FIN: o_finish=1 for 1 cycle -> IDLE.
- o_busy=1 in all states except IDLE.
- Row pointers are monotonic. A malformed pointer (end<cur) is treated as an empty row.
- i_start while busy: ignored.

Optional Feature:
- Macro FEEDER_ZERO_SKIP_EN.
- Defined: elements whose value reads as 0 get o_rdy=0 (the slot is still consumed, timing unchanged). A row whose elements are all zero therefore emits nothing.
- Undefined: every stored element is emitted.

Test Plan:
- 4x32 matrix (N_ROWS=4), rows with nnz 2,0,1,3 (rp=0,2,2,3,6) -> per pass 6 o_rdy cycles, rows 0,0,2,3,3,3 in order. Cols/values match SRAM. o_done 1 cycle after the last element; 4 passes, then o_finish.
- Weight load, pass p=1: i_w_switch held high 64 cycles starting 2 cycles after o_switch -> words arrive in order (col2,r0),(col3,r0),(col2,r1)...(col3,r31), o_w_data = W[col][row] each cycle.
- i_w_switch delayed 10 cycles after o_switch -> o_w_data holds W[2p][0] and o_w_addr is stable until i_w_switch rises.
- All rows empty (rp all 0) -> no o_rdy. Each pass gives o_done about 2*N_ROWS+2 cycles after W_LOAD exits.
- rst low mid-ELEM, then high -> all outputs 0, o_busy=0; a new i_start restarts at p=0 with an o_switch pulse.
- FEEDER_ZERO_SKIP_EN, row 0 values {0,5} -> single o_rdy with o_data=5; with the macro undefined, two o_rdy cycles with o_data 0 then 5.

Source files
------------

// File: rtl/csr_stream_feeder.sv
// csr_stream_feeder: transmit end of the scheduler input protocol.
// For every pair of weight columns it streams the 64 interleaved weight
// words, then walks the CSR input matrix and emits each nonzero element
// (value, row, column), closing each pass with a done pulse. After the last
// pair it raises finish.
//
// Optional feature macro: FEEDER_ZERO_SKIP_EN
//   defined   : elements whose value reads as zero keep their slot but are
//               not flagged valid (o_rdy stays low for that cycle).
//   undefined : every stored element is emitted.
module csr_stream_feeder #(
    parameter int DATA_BITS  = 16,
    parameter int N_ROWS     = 100,
    parameter int ROW_BITS   = 7,
    parameter int COL_BITS   = 5,
    parameter int W_ROWS     = 32,
    parameter int W_COLS     = 8,
    parameter int WCOL_BITS  = 3,
    parameter int NNZ_BITS   = 12,
    parameter int WADDR_BITS = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    output logic [ROW_BITS-1:0]   o_rp_addr,
    input  logic [NNZ_BITS-1:0]   i_rp_rdata,
    output logic [NNZ_BITS-1:0]   o_nz_addr,
    input  logic [DATA_BITS-1:0]  i_nz_val,
    input  logic [COL_BITS-1:0]   i_nz_col,
    output logic [WADDR_BITS-1:0] o_w_addr,
    input  logic [DATA_BITS-1:0]  i_w_rdata,
    output logic                  o_rdy,
    output logic [DATA_BITS-1:0]  o_data,
    output logic [ROW_BITS-1:0]   o_row_ptr,
    output logic [COL_BITS-1:0]   o_col_idx,
    output logic                  o_done,
    output logic                  o_switch,
    output logic [DATA_BITS-1:0]  o_w_data,
    output logic [WCOL_BITS-1:0]  o_w_col_idx,
    input  logic                  i_w_switch,
    output logic                  o_busy,
    output logic                  o_finish
);

    // Two weight words per row (one per column of the pair)
    localparam int W_WORDS = 2 * W_ROWS;
    localparam int K_BITS  = $clog2(W_WORDS);
    localparam int P_BITS  = WCOL_BITS - 1;

    localparam logic [K_BITS-1:0]   LAST_K    = K_BITS'(W_WORDS - 1);
    localparam logic [ROW_BITS-1:0] LAST_ROW  = ROW_BITS'(N_ROWS - 1);
    localparam logic [P_BITS-1:0]   LAST_PAIR = P_BITS'(W_COLS / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_W_REQ,
        S_W_LOAD,
        S_RP_INIT,
        S_RP_FETCH,
        S_ELEM,
        S_DONE,
        S_FIN
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [P_BITS-1:0]    pair;
    logic [K_BITS-1:0]    k;
    logic [ROW_BITS-1:0]  r;
    logic                 fetch_ph;
    logic                 init_pend;
    logic [NNZ_BITS-1:0]  cur_ptr;
    logic [NNZ_BITS-1:0]  end_ptr;
    logic                 elem_v;
    logic [ROW_BITS-1:0]  elem_row;

    logic                 w_last;
    logic                 row_empty;
    logic                 last_row;
    logic                 elem_last;
    logic                 elem_emit;
    logic [K_BITS-1:0]    k_sel;

    // Weight word kk of the current pair: even words belong to column 2p,
    // odd words to column 2p+1, and the row advances every two words.
    function automatic logic [WCOL_BITS-1:0] word_col(
        input logic [P_BITS-1:0] pr,
        input logic [K_BITS-1:0] kk
    );
        word_col = {pr, kk[0]};
    endfunction

    function automatic logic [WADDR_BITS-1:0] word_addr(
        input logic [P_BITS-1:0] pr,
        input logic [K_BITS-1:0] kk
    );
        logic [WCOL_BITS-1:0] col;
        logic [K_BITS-2:0]    row;
        col = word_col(pr, kk);
        row = kk[K_BITS-1:1];
        word_addr = WADDR_BITS'(col) * WADDR_BITS'(W_ROWS) + WADDR_BITS'(row);
    endfunction

    assign w_last    = (k == LAST_K) && i_w_switch;
    // A pointer that does not advance (or goes backwards) means no elements
    assign row_empty = (i_rp_rdata <= cur_ptr);
    assign last_row  = (r == LAST_ROW);
    assign elem_last = ((cur_ptr + NNZ_BITS'(1)) == end_ptr);
    assign k_sel     = i_w_switch ? (k + K_BITS'(1)) : k;

`ifdef FEEDER_ZERO_SKIP_EN
    assign elem_emit = elem_v && (i_nz_val != '0);
`else
    assign elem_emit = elem_v;
`endif

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decision
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:     if (i_start) state_nxt = S_W_REQ;
            S_W_REQ:    state_nxt = S_W_LOAD;
            S_W_LOAD:   if (w_last) state_nxt = S_RP_INIT;
            S_RP_INIT:  state_nxt = S_RP_FETCH;
            S_RP_FETCH: begin
                if (fetch_ph) begin
                    if (!row_empty) begin
                        state_nxt = S_ELEM;
                    end else if (last_row) begin
                        state_nxt = S_DONE;
                    end
                end
            end
            S_ELEM: begin
                if (elem_last) begin
                    state_nxt = last_row ? S_DONE : S_RP_FETCH;
                end
            end
            S_DONE: begin
                if (!elem_v) begin
                    state_nxt = (pair == LAST_PAIR) ? S_FIN : S_W_REQ;
                end
            end
            S_FIN:      state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    // Counters, row pointers and the one-cycle element pipeline stage
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pair      <= '0;
            k         <= '0;
            r         <= '0;
            fetch_ph  <= 1'b0;
            init_pend <= 1'b0;
            cur_ptr   <= '0;
            end_ptr   <= '0;
            elem_v    <= 1'b0;
            elem_row  <= '0;
        end else begin
            elem_v   <= (state == S_ELEM);
            elem_row <= r;
            case (state)
                S_IDLE: begin
                    if (i_start) pair <= '0;
                end
                S_W_REQ: begin
                    k <= '0;
                end
                S_W_LOAD: begin
                    if (i_w_switch) k <= k + K_BITS'(1);
                end
                S_RP_INIT: begin
                    r         <= '0;
                    fetch_ph  <= 1'b0;
                    init_pend <= 1'b1;
                end
                S_RP_FETCH: begin
                    if (!fetch_ph) begin
                        fetch_ph <= 1'b1;
                        if (init_pend) begin
                            cur_ptr   <= i_rp_rdata;
                            init_pend <= 1'b0;
                        end
                    end else begin
                        fetch_ph <= 1'b0;
                        if (row_empty) begin
                            if (!last_row) r <= r + ROW_BITS'(1);
                        end else begin
                            end_ptr <= i_rp_rdata;
                        end
                    end
                end
                S_ELEM: begin
                    cur_ptr <= cur_ptr + NNZ_BITS'(1);
                    if (elem_last) begin
                        r        <= r + ROW_BITS'(1);
                        fetch_ph <= 1'b0;
                    end
                end
                S_DONE: begin
                    if (!elem_v) pair <= pair + P_BITS'(1);
                end
                default: ;
            endcase
        end
    end

    // Output decode: SRAM addresses, protocol pulses and gated data outputs
    always_comb begin
        o_rp_addr   = '0;
        o_nz_addr   = '0;
        o_w_addr    = '0;
        o_w_data    = '0;
        o_w_col_idx = '0;
        o_switch    = 1'b0;
        o_done      = 1'b0;
        o_finish    = 1'b0;
        o_busy      = (state != S_IDLE);
        o_rdy       = elem_emit;
        o_data      = elem_emit ? i_nz_val : '0;
        o_row_ptr   = elem_emit ? elem_row : '0;
        o_col_idx   = elem_emit ? i_nz_col : '0;
        case (state)
            S_W_REQ: begin
                o_switch = 1'b1;
                o_w_addr = word_addr(pair, '0);
            end
            S_W_LOAD: begin
                o_w_addr    = word_addr(pair, k_sel);
                o_w_data    = i_w_rdata;
                o_w_col_idx = word_col(pair, k);
            end
            S_RP_INIT: begin
                o_rp_addr = '0;
            end
            S_RP_FETCH: begin
                o_rp_addr = r + ROW_BITS'(1);
            end
            S_ELEM: begin
                o_nz_addr = cur_ptr;
            end
            S_DONE: begin
                o_done = !elem_v;
            end
            S_FIN: begin
                o_finish = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_csr_stream_feeder.sv
// tb_csr_stream_feeder: directed bench for csr_stream_feeder with a
// 4-row input matrix (nnz per row 2,0,1,3), behavioural 1-cycle SRAMs and a
// scripted scheduler driving i_w_switch.
module tb_csr_stream_feeder;

    localparam int N_ROWS = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_start;
    logic [6:0]  o_rp_addr;
    logic [11:0] i_rp_rdata;
    logic [11:0] o_nz_addr;
    logic [15:0] i_nz_val;
    logic [4:0]  i_nz_col;
    logic [7:0]  o_w_addr;
    logic [15:0] i_w_rdata;
    logic        o_rdy;
    logic [15:0] o_data;
    logic [6:0]  o_row_ptr;
    logic [4:0]  o_col_idx;
    logic        o_done;
    logic        o_switch;
    logic [15:0] o_w_data;
    logic [2:0]  o_w_col_idx;
    logic        i_w_switch;
    logic        o_busy;
    logic        o_finish;

    logic [11:0] rp_mem [0:7];
    logic [15:0] nz_val_mem [0:15];
    logic [4:0]  nz_col_mem [0:15];
    logic [15:0] w_mem [0:255];
    int          row_tab [0:5];

    int          exp_cnt;
    logic [15:0] exp_data [0:7];
    int          exp_row [0:7];
    int          exp_col [0:7];

    int n_compared = 0;
    int n_mismatched = 0;

    csr_stream_feeder #(.N_ROWS(N_ROWS)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_start     (i_start),
        .o_rp_addr   (o_rp_addr),
        .i_rp_rdata  (i_rp_rdata),
        .o_nz_addr   (o_nz_addr),
        .i_nz_val    (i_nz_val),
        .i_nz_col    (i_nz_col),
        .o_w_addr    (o_w_addr),
        .i_w_rdata   (i_w_rdata),
        .o_rdy       (o_rdy),
        .o_data      (o_data),
        .o_row_ptr   (o_row_ptr),
        .o_col_idx   (o_col_idx),
        .o_done      (o_done),
        .o_switch    (o_switch),
        .o_w_data    (o_w_data),
        .o_w_col_idx (o_w_col_idx),
        .i_w_switch  (i_w_switch),
        .o_busy      (o_busy),
        .o_finish    (o_finish)
    );

    always #5 clk = ~clk;

    // Behavioural SRAMs with one cycle of read latency
    always @(posedge clk) begin
        i_rp_rdata <= rp_mem[o_rp_addr[2:0]];
        i_nz_val   <= nz_val_mem[o_nz_addr[3:0]];
        i_nz_col   <= nz_col_mem[o_nz_addr[3:0]];
        i_w_rdata  <= w_mem[o_w_addr];
    end

    // Hard stop in case a wait escapes its own bound
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Pulse i_start for one cycle
    task automatic applyStimulus();
        @(negedge clk);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic waitSwitch(input string tag);
        for (int i = 0; i < 60 && !o_switch; i++) @(negedge clk);
        checkOutput(tag, o_switch, 1);
    endtask

    // Build the expected element list from the stored tables
    task automatic setExpected();
        exp_cnt = 0;
        for (int i = 0; i < 6; i++) begin
`ifdef FEEDER_ZERO_SKIP_EN
            if (nz_val_mem[i] != 16'h0) begin
`else
            begin
`endif
                exp_data[exp_cnt] = nz_val_mem[i];
                exp_row[exp_cnt]  = row_tab[i];
                exp_col[exp_cnt]  = int'(nz_col_mem[i]);
                exp_cnt++;
            end
        end
    endtask

    // Weight-load handshake for pair p, i_w_switch first rising dly cycles after o_switch
    task automatic loadWeights(input int p, input int dly, input bit poke);
        int col;
        int row;
        int a0;
        waitSwitch("switch_pulse");
        checkOutput("busy_wreq", o_busy, 1);
        a0 = 2 * p * 32;
        @(negedge clk);
        for (int i = 0; i < dly - 1; i++) begin
            i_start = poke && (i == 0);
            checkOutput("hold_wdata", o_w_data, w_mem[a0]);
            checkOutput("hold_waddr", o_w_addr, a0);
            checkOutput("hold_wcol", o_w_col_idx, 2 * p);
            @(negedge clk);
        end
        i_start = 1'b0;
        for (int j = 0; j < 64; j++) begin
            col = 2 * p + (j % 2);
            row = j / 2;
            checkOutput("wload_data", o_w_data, w_mem[col * 32 + row]);
            checkOutput("wload_col", o_w_col_idx, col);
            i_w_switch = 1'b1;
            @(negedge clk);
        end
        i_w_switch = 1'b0;
    endtask

    // Collect one pass of elements until o_done, then check pass-level timing
    task automatic streamPass(input bit last, input bit empty_chk);
        int e;
        int leak;
        int last_rdy;
        int done_c;
        bit seen;
        e = 0;
        leak = 0;
        last_rdy = -1;
        done_c = -1;
        seen = 1'b0;
        for (int c = 0; c < 300; c++) begin
            if (o_rdy) begin
                if (e < 8) begin
                    checkOutput("elem_data", o_data, exp_data[e]);
                    checkOutput("elem_row", o_row_ptr, exp_row[e]);
                    checkOutput("elem_col", o_col_idx, exp_col[e]);
                end
                last_rdy = c;
                e++;
            end else if (o_data != 0 || o_row_ptr != 0 || o_col_idx != 0) begin
                leak++;
            end
            if (o_done) begin
                seen = 1'b1;
                done_c = c;
                break;
            end
            @(negedge clk);
        end
        checkOutput("done_seen", seen, 1);
        checkOutput("elem_cnt", e, exp_cnt);
        checkOutput("quiet_when_idle", leak, 0);
        if (exp_cnt > 0) checkOutput("done_latency", done_c - last_rdy, 1);
        if (empty_chk) checkOutput("empty_done_window",
                                   (done_c >= 2 * N_ROWS) && (done_c <= 2 * N_ROWS + 3), 1);
        if (last) begin
            @(negedge clk);
            checkOutput("finish_pulse", o_finish, 1);
            checkOutput("busy_fin", o_busy, 1);
            @(negedge clk);
            checkOutput("finish_clear", o_finish, 0);
            checkOutput("idle_after_fin", o_busy, 0);
        end
    endtask

    task automatic runJob(input int dly0, input bit empty_chk, input bit poke);
        for (int p = 0; p < 4; p++) begin
            loadWeights(p, (p == 0) ? dly0 : ((p == 1) ? 2 : 3), poke && (p == 0));
            streamPass(p == 3, empty_chk);
        end
    endtask

    initial begin
        rst = 1'b0;
        i_start = 1'b0;
        i_w_switch = 1'b0;
        for (int a = 0; a < 256; a++) w_mem[a] = 16'h4000 + 16'(a * 3);
        for (int a = 0; a < 16; a++) begin
            nz_val_mem[a] = 16'h0;
            nz_col_mem[a] = 5'd0;
        end
        for (int a = 0; a < 8; a++) rp_mem[a] = 12'd6;
        rp_mem[0] = 12'd0; rp_mem[1] = 12'd2; rp_mem[2] = 12'd2;
        rp_mem[3] = 12'd3; rp_mem[4] = 12'd6;
        nz_val_mem[0] = 16'h1111; nz_val_mem[1] = 16'h2222; nz_val_mem[2] = 16'h3333;
        nz_val_mem[3] = 16'h4444; nz_val_mem[4] = 16'h5555; nz_val_mem[5] = 16'h6666;
        nz_col_mem[0] = 5'd3;  nz_col_mem[1] = 5'd7;  nz_col_mem[2] = 5'd1;
        nz_col_mem[3] = 5'd0;  nz_col_mem[4] = 5'd31; nz_col_mem[5] = 5'd15;
        row_tab[0] = 0; row_tab[1] = 0; row_tab[2] = 2;
        row_tab[3] = 3; row_tab[4] = 3; row_tab[5] = 3;

        repeat (3) @(negedge clk);
        checkOutput("rst_busy", o_busy, 0);
        checkOutput("rst_rdy", o_rdy, 0);
        checkOutput("rst_switch", o_switch, 0);
        checkOutput("rst_done", o_done, 0);
        checkOutput("rst_finish", o_finish, 0);
        checkOutput("rst_waddr", o_w_addr, 0);
        checkOutput("rst_data", o_data, 0);
        rst = 1'b1;
        @(negedge clk);

        $display("[TB] job A: nominal matrix, delayed weight handshake, start while busy");
        setExpected();
        applyStimulus();
        runJob(10, 1'b0, 1'b1);

        $display("[TB] job B: reset during element streaming");
        applyStimulus();
        loadWeights(0, 2, 1'b0);
        for (int i = 0; i < 40 && !o_rdy; i++) @(negedge clk);
        checkOutput("rdy_before_rst", o_rdy, 1);
        rst = 1'b0;
        #1;
        checkOutput("abort_busy", o_busy, 0);
        checkOutput("abort_rdy", o_rdy, 0);
        checkOutput("abort_data", o_data, 0);
        checkOutput("abort_nzaddr", o_nz_addr, 0);
        repeat (3) @(negedge clk);
        checkOutput("abort_no_done", o_done, 0);
        checkOutput("abort_no_finish", o_finish, 0);
        rst = 1'b1;
        @(negedge clk);

        $display("[TB] job C: restart after reset, row 0 values {0,5}");
        nz_val_mem[0] = 16'h0000;
        nz_val_mem[1] = 16'h0005;
        setExpected();
        applyStimulus();
        runJob(2, 1'b0, 1'b0);

        $display("[TB] job D: all rows empty");
        for (int a = 0; a < 8; a++) rp_mem[a] = 12'd0;
        exp_cnt = 0;
        applyStimulus();
        runJob(2, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
